// File: rtl/sram_responder_pkg.sv
// Shared types and helpers for the SRAM responder: bus edge classification,
// host FSM states and a saturating counter step.
package sram_responder_pkg;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_GRANT = 2'd1,
    H_RESP  = 2'd2
  } host_state_e;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WR   = 2'd1,
    BUS_RD   = 2'd2,
    BUS_BAD  = 2'd3
  } bus_op_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Write wins over read; any other selected combination is a protocol error.
  function automatic bus_op_e classify(input logic cs_n, input logic we_n,
                                       input logic oe_n, input logic output_en);
    if (cs_n)                   return BUS_IDLE;
    else if (!we_n && output_en) return BUS_WR;
    else if (we_n && !oe_n)     return BUS_RD;
    else                        return BUS_BAD;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port DEPTH x 8 storage: synchronous write, registered read.
// Contents are deliberately not reset.
module sram_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Bus-side SRAM model with a host preload/dump port that only gets the array
// when the bus has been idle for two consecutive edges.
//
// state   | meaning
// H_IDLE  | waiting for host_valid with the bus idle on two edges
// H_GRANT | host_ready high (unless cs_n drops); access happens at the edge
// H_RESP  | host_rvalid pulse carrying the read byte
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  input  logic              output_en,
  input  logic              cs_n,
  input  logic              oe_n,
  input  logic              we_n,
  output logic [7:0]        data_out,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic              err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  host_state_e state_q, state_d;
  bus_op_e     op;
  logic        bus_inr, host_inr, host_go, bus_acc;
  logic        arr_en, arr_we;
  logic [AW-1:0] arr_addr;
  logic [7:0]  arr_wdata, arr_rdata;

  logic        idle_prev_q, idle_prev_d;
  logic        dout_live_q, dout_live_d;
  logic [7:0]  dout_hold_q, dout_hold_d;
  logic        host_inr_q, host_inr_d;
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic        err_q, err_d;

  assign op       = classify(cs_n, we_n, oe_n, output_en);
  assign bus_inr  = {1'b0, addr} < DEPTH_X;
  assign host_inr = {1'b0, host_addr} < DEPTH_X;
  assign bus_acc  = (op == BUS_WR) || (op == BUS_RD);
  // A falling cs_n during the grant cycle cancels the host access.
  assign host_go  = (state_q == H_GRANT) && cs_n;

  assign arr_en    = rst_n && (host_go ? host_inr : (bus_acc && bus_inr));
  assign arr_we    = host_go ? host_we : (op == BUS_WR);
  assign arr_addr  = host_go ? host_addr[AW-1:0] : addr[AW-1:0];
  assign arr_wdata = host_go ? host_wdata : data_in;

  sram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= H_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      H_IDLE:  if (host_valid && (op == BUS_IDLE) && idle_prev_q) state_d = H_GRANT;
      H_GRANT: state_d = (!cs_n || host_we) ? H_IDLE : H_RESP;
      H_RESP:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  always_comb begin
    host_ready  = (state_q == H_GRANT) && cs_n;
    host_rvalid = (state_q == H_RESP);
    host_rdata  = ((state_q == H_RESP) && host_inr_q) ? arr_rdata : 8'h00;
  end

  // data_out follows the array output until a host read reuses the port;
  // the current byte is then parked in dout_hold_q.
  assign data_out = dout_live_q ? arr_rdata : dout_hold_q;

  always_comb begin
    idle_prev_d = (op == BUS_IDLE);
    dout_live_d = dout_live_q;
    dout_hold_d = dout_hold_q;
    host_inr_d  = host_inr_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    err_d       = err_q;
    if (op == BUS_RD) begin
      rd_cnt_d    = sat_inc(rd_cnt_q);
      dout_live_d = bus_inr;
      if (!bus_inr) dout_hold_d = 8'h00;
    end
    if (op == BUS_WR) wr_cnt_d = sat_inc(wr_cnt_q);
    if ((bus_acc && !bus_inr) || (op == BUS_BAD)) err_d = 1'b1;
    if (host_go) begin
      host_inr_d = host_inr;
      if (!host_inr) err_d = 1'b1;
      if (!host_we) begin
        dout_hold_d = data_out;
        dout_live_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_prev_q <= 1'b0;
      dout_live_q <= 1'b0;
      dout_hold_q <= 8'h00;
      host_inr_q  <= 1'b0;
      rd_cnt_q    <= 16'h0000;
      wr_cnt_q    <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      idle_prev_q <= idle_prev_d;
      dout_live_q <= dout_live_d;
      dout_hold_q <= dout_hold_d;
      host_inr_q  <= host_inr_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      err_q       <= err_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against a byte-array reference model.
module tb_sram_responder;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_in;
  logic              output_en, cs_n, oe_n, we_n;
  logic [7:0]        data_out;
  logic              host_valid, host_ready, host_we, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata, host_rdata;
  logic [15:0]       rd_cnt, wr_cnt;
  logic              err;

  sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .output_en(output_en), .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n),
    .data_out(data_out), .host_valid(host_valid), .host_ready(host_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [0:DEPTH-1];
  logic [7:0] exp_dout;
  int         exp_rd, exp_wr;
  logic       exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic bit in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Apply the effect of one rising edge using the values currently driven.
  task automatic model_edge();
    if (!rst_n) begin
      exp_dout = 8'h00; exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
      return;
    end
    if (!cs_n) begin
      if (!we_n && output_en) begin
        exp_wr = sat16(exp_wr);
        if (in_range(addr)) mem_m[addr[11:0]] = data_in;
        else exp_err = 1'b1;
      end else if (we_n && !oe_n) begin
        exp_rd = sat16(exp_rd);
        if (in_range(addr)) exp_dout = mem_m[addr[11:0]];
        else begin exp_dout = 8'h00; exp_err = 1'b1; end
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic drive_bus(input logic c, input logic w, input logic o, input logic en,
                           input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cs_n = c; we_n = w; oe_n = o; output_en = en; addr = a; data_in = d;
  endtask

  task automatic tick(input string tag, input bit check);
    @(posedge clk);
    model_edge();
    #1;
    if (check) begin
      chk({tag, "_dout"}, 32'(data_out), 32'(exp_dout));
      chk({tag, "_rdcnt"}, 32'(rd_cnt), 32'(exp_rd));
      chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'(exp_wr));
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
    end
  endtask

  task automatic bus_rd(input string tag, input logic [ADDR_W-1:0] a);
    drive_bus(1'b0, 1'b1, 1'b0, 1'($urandom), a, 8'($urandom));
    tick(tag, 1'b1);
  endtask

  task automatic bus_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    drive_bus(1'b0, 1'b0, 1'($urandom), 1'b1, a, d);
    tick(tag, 1'b1);
  endtask

  task automatic bus_idle(input string tag);
    drive_bus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 17'($urandom), 8'($urandom));
    tick(tag, 1'b1);
  endtask

  task automatic host_access(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [7:0] wd);
    bit got;
    logic [7:0] exp_h;
    host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      bus_idle(tag);
      if (host_ready) got = 1;
    end
    chk({tag, "_ready_seen"}, 32'(got), 32'd1);
    if (!got) begin
      host_valid = 1'b0;
      return;
    end
    exp_h = in_range(a) ? mem_m[a[11:0]] : 8'h00;
    if (!in_range(a)) exp_err = 1'b1;
    else if (we) mem_m[a[11:0]] = wd;
    bus_idle(tag);
    host_valid = 1'b0;
    chk({tag, "_ready_drop"}, 32'(host_ready), 32'd0);
    if (we) begin
      chk({tag, "_no_rvalid"}, 32'(host_rvalid), 32'd0);
    end else begin
      chk({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
      chk({tag, "_rdata"}, 32'(host_rdata), 32'(exp_h));
      bus_idle(tag);
      chk({tag, "_rvalid_end"}, 32'(host_rvalid), 32'd0);
    end
  endtask

  task automatic rand_cycle(input string tag, input bit allow_bad);
    int op;
    logic [ADDR_W-1:0] a;
    op = allow_bad ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
    a  = 17'($urandom_range(0, 15));
    if (allow_bad && ($urandom_range(0, 7) == 0))
      a = ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'(DEPTH + int'($urandom_range(0, 100)));
    case (op)
      0: bus_idle(tag);
      1: bus_rd(tag, a);
      2: bus_wr(tag, a, 8'($urandom));
      default: begin
        if ($urandom_range(0, 1) == 0) drive_bus(1'b0, 1'b0, 1'($urandom), 1'b0, a, 8'($urandom));
        else                           drive_bus(1'b0, 1'b1, 1'b1, 1'($urandom), a, 8'($urandom));
        tick(tag, 1'b1);
      end
    endcase
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick(tag, 1'b1);
    chk({tag, "_ready"}, 32'(host_ready), 32'd0);
    chk({tag, "_rvalid"}, 32'(host_rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(host_rdata), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int nrdy, nrv;
    bit drop, got;
    logic [7:0] rv_data, exp_h, old9;

    rst_n = 1'b0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    drive_bus(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    exp_dout = 8'h00; exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
    @(posedge clk); @(posedge clk);
    #1;
    do_reset("reset");

    // Host preload then bus read of the same byte.
    host_access("h_wr5", 1'b1, 17'd5, 8'hA5);
    bus_rd("rd5", 17'd5);
    chk("rd5_value", 32'(data_out), 32'hA5);
    chk("rd5_cnt", 32'(rd_cnt), 32'd1);

    bus_wr("wr100", 17'h00100, 8'h3C);
    bus_rd("rd100", 17'h00100);
    chk("rd100_value", 32'(data_out), 32'h3C);
    chk("wr100_cnt", 32'(wr_cnt), 32'd1);

    for (int i = 0; i < 16; i++) bus_wr("init", 17'(i), 8'($urandom));
    for (int i = 0; i < 200; i++) rand_cycle("rndA", 1'b0);

    // Write attempted without output_en is a protocol error and writes nothing.
    bus_wr("pre_bad", 17'd3, 8'h5A);
    drive_bus(1'b0, 1'b0, 1'b1, 1'b0, 17'd3, 8'hEE);
    tick("bad_wr", 1'b1);
    bus_rd("bad_rd", 17'd3);
    chk("bad_keep", 32'(data_out), 32'h5A);
    chk("bad_err", 32'(err), 32'd1);

    // Host read starved by a busy bus, then a grant cancelled by cs_n.
    host_valid = 1'b1; host_we = 1'b0; host_addr = 17'd5;
    exp_h = mem_m[5];
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) bus_rd("starve", 17'd0);
      else            bus_idle("starve");
      chk("starve_noready", 32'(host_ready), 32'd0);
    end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      bus_idle("pre_cancel");
      if (host_ready) got = 1;
    end
    chk("cancel_grant_seen", 32'(got), 32'd1);
    drive_bus(1'b0, 1'b1, 1'b0, 1'b0, 17'd1, 8'h00);
    #1;
    chk("cancel_ready_low", 32'(host_ready), 32'd0);
    tick("cancel_rd", 1'b1);
    nrdy = 0; nrv = 0; drop = 0; rv_data = 8'h00;
    for (int i = 0; i < 20; i++) begin
      bus_idle("resume");
      if (drop) host_valid = 1'b0;
      if (host_ready) nrdy++;
      if (host_rvalid) begin nrv++; rv_data = host_rdata; end
      drop = host_ready;
    end
    host_valid = 1'b0;
    chk("resume_ready_pulses", 32'(nrdy), 32'd1);
    chk("resume_rvalid_pulses", 32'(nrv), 32'd1);
    chk("resume_rdata", 32'(rv_data), 32'(exp_h));

    for (int i = 0; i < 200; i++) rand_cycle("rndB", 1'b1);
    host_access("h_rd_mid", 1'b0, 17'($urandom_range(0, 15)), 8'h00);

    bus_rd("rd_oob", 17'd4096);
    chk("rd_oob_zero", 32'(data_out), 32'h00);
    chk("rd_oob_err", 32'(err), 32'd1);
    for (int i = 0; i < 70000; i++) begin
      drive_bus(1'b0, 1'b1, 1'b0, 1'b0, 17'd2, 8'h00);
      tick("sat", 1'b0);
    end
    bus_idle("sat_end");
    chk("rd_sat", 32'(rd_cnt), 32'hFFFF);

    // Reset during the grant cycle of a host write must not write memory.
    bus_wr("pre9", 17'd9, 8'h11);
    old9 = mem_m[9];
    host_valid = 1'b1; host_we = 1'b1; host_addr = 17'd9; host_wdata = 8'h77;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      bus_idle("pre_rst");
      if (host_ready) got = 1;
    end
    chk("rst_grant_seen", 32'(got), 32'd1);
    do_reset("rst_mid");
    host_valid = 1'b0;
    bus_idle("post_rst");
    bus_idle("post_rst");
    bus_rd("rd9", 17'd9);
    chk("rd9_unchanged", 32'(data_out), 32'(old9));

    host_access("h_rd_oob", 1'b0, 17'd4096, 8'h00);
    chk("h_oob_err", 32'(err), 32'd1);
    host_access("h_wr_rd", 1'b1, 17'd12, 8'($urandom));
    host_access("h_rd12", 1'b0, 17'd12, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
